// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Sends in-order requests to instruction memory (valid/ready) and takes
// responses on a valid-only channel. Returned words are buffered in a small
// FIFO, so memory latency and downstream stalls are decoupled. A redirect
// flushes the buffer and silently discards responses that are still in flight.
// Optional feature: define IF_PERF_EN to add the stall_cycles starvation counter.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_running,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        keep_instr,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr_IF,
    output logic        instr_valid
`ifdef IF_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Fetch state and occupancy counters
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_out_cnt;    // requests accepted, response not yet seen
    logic [CNT_W-1:0] r_drop_cnt;   // in-flight responses that belong to a dead path
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [PTR_W-1:0] r_fifo_wp;
    logic [PTR_W-1:0] r_fifo_rp;
    logic [PTR_W-1:0] r_aq_wp;
    logic [PTR_W-1:0] r_aq_rp;

    // Storage: instruction buffer and address queue of in-flight requests
    logic [31:0] r_fifo_addr [FIFO_DEPTH];
    logic [31:0] r_fifo_data [FIFO_DEPTH];
    logic [31:0] r_aq_addr   [FIFO_DEPTH];

    logic w_space;
    logic w_req_valid;
    logic w_req_accept;
    logic w_rsp_dropped;
    logic w_fifo_push;
    logic w_fifo_pop;
    logic w_empty;

    // Counting in-flight requests against free buffer slots means every
    // response always has a place to land, so the FIFO can never overflow.
    assign w_space       = ({1'b0, r_out_cnt} + {1'b0, r_fifo_cnt}) < DEPTH_C;
    assign w_req_valid   = ~rst & pc_running & ~branch_valid & w_space;
    assign w_req_accept  = w_req_valid & imem_req_ready;
    assign w_rsp_dropped = imem_rsp_valid & (r_drop_cnt != '0);
    assign w_fifo_push   = imem_rsp_valid & ~w_rsp_dropped & ~branch_valid;
    assign w_empty       = (r_fifo_cnt == '0);
    assign w_fifo_pop    = ~w_empty & ~keep_instr & ~branch_valid;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

    assign instr_valid = ~w_empty;
    assign pc          = w_empty ? 32'h0 : r_fifo_addr[r_fifo_rp];
    assign instr_IF    = w_empty ? 32'h0 : r_fifo_data[r_fifo_rp];

    // Fetch pointer, outstanding/drop bookkeeping and buffer pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_fifo_cnt <= '0;
            r_fifo_wp  <= '0;
            r_fifo_rp  <= '0;
            r_aq_wp    <= '0;
            r_aq_rp    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            if (branch_valid) begin
                r_fetch_pc <= branch_target & 32'hFFFF_FFFC;
            end else if (w_req_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            // The address queue tracks every in-flight request, including
            // those on a dead path, so it is never flushed by a redirect.
            if (w_req_accept) begin
                r_aq_wp <= r_aq_wp + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                r_aq_rp <= r_aq_rp + PTR_W'(1);
            end

            case ({w_req_accept, imem_rsp_valid})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase

            // On a redirect everything still in flight after this edge is stale;
            // a response arriving this cycle is already retired either way.
            if (branch_valid) begin
                r_drop_cnt <= r_out_cnt - CNT_W'(imem_rsp_valid);
            end else if (w_rsp_dropped) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end

            if (branch_valid) begin
                r_fifo_cnt <= '0;
                r_fifo_wp  <= '0;
                r_fifo_rp  <= '0;
            end else begin
                if (w_fifo_push) begin
                    r_fifo_wp <= r_fifo_wp + PTR_W'(1);
                end
                if (w_fifo_pop) begin
                    r_fifo_rp <= r_fifo_rp + PTR_W'(1);
                end
                case ({w_fifo_push, w_fifo_pop})
                    2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                    2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                    default: r_fifo_cnt <= r_fifo_cnt;
                endcase
            end
        end
    end

    // Storage writes: capture request addresses and returned {addr, data}
    // NOTE: the arrays carry no reset; the pointers and counts alone define
    // which entries are valid, and outputs are gated while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_req_accept) begin
            r_aq_addr[r_aq_wp] <= r_fetch_pc;
        end
        if (w_fifo_push) begin
            r_fifo_addr[r_fifo_wp] <= r_aq_addr[r_aq_rp];
            r_fifo_data[r_fifo_wp] <= imem_rsp_data;
        end
    end

`ifdef IF_PERF_EN
    // Starvation counter: running, nothing to present and downstream not stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_running & w_empty & ~keep_instr & (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized scoreboard bench for if_fetch_unit.
// The reference is the program-order instruction stream: starting at RESET_PC,
// consecutive words, restarting at the aligned target on every redirect.
// The stimulus process drives inputs, models an in-order memory and pushes
// expected {pc, instr} pairs; the monitor pops one per consumed instruction.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0100;
    localparam int          FIFO_DEPTH = 2;
    localparam int          N_CYCLES   = 3000;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        pc_running     = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        keep_instr     = 1'b0;
    logic        branch_valid   = 1'b0;
    logic [31:0] branch_target  = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] pc;
    logic [31:0] instr_IF;
    logic        instr_valid;
`ifdef IF_PERF_EN
    logic [31:0] stall_cycles;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];   // requests accepted by the memory model
    logic [63:0] exp_q[$];   // expected {pc, instr} in program order
    logic [31:0] ref_pc;     // next program-order pc to enqueue
    logic [31:0] req_pc_m;   // address the next request must carry
    logic [31:0] prev_addr;
    logic        prev_wait;
    logic [31:0] exp_stall;
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          consumed = 0;

    if_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_running     (pc_running),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .keep_instr     (keep_instr),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .pc             (pc),
        .instr_IF       (instr_IF),
        .instr_valid    (instr_valid)
`ifdef IF_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Contents of instruction memory: a fixed scramble of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus and memory model; inputs change on the falling edge
    initial begin
        int keep_run;
        keep_run       = 0;
        ref_pc         = RESET_PC;
        pc_running     = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            cyc = i;
            rst = (i < 3) || (i >= 1500 && i < 1503);
            if (rst) begin
                mem_q.delete();
                exp_q.delete();
                ref_pc = RESET_PC;
            end
            pc_running     = ($urandom_range(0, 9) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if (keep_run > 0) begin
                keep_instr = 1'b1;
                keep_run--;
            end else if ($urandom_range(0, 7) == 0) begin
                keep_instr = 1'b1;
                keep_run   = int'($urandom_range(0, 5));
            end else begin
                keep_instr = 1'b0;
            end
            branch_valid  = !rst && ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            #1;
            if (!rst) begin
                if (imem_rsp_valid) begin
                    void'(mem_q.pop_front());
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(0, 3))});
                end
                if (branch_valid) begin
                    exp_q.delete();
                    ref_pc = branch_target & 32'hFFFF_FFFC;
                end
                while (exp_q.size() < 4) begin
                    exp_q.push_back({ref_pc, mem_word(ref_pc)});
                    ref_pc += 32'd4;
                end
            end
        end
        @(negedge clk);
        #3;
        check("min_consumed", (consumed >= 150) ? 32'd1 : 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: samples outputs shortly after the falling edge
    initial begin
        logic [63:0] e;
        req_pc_m  = RESET_PC;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        exp_stall = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
                check("rst_pc", pc, 32'h0);
                check("rst_instr", instr_IF, 32'h0);
                check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
                check("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef IF_PERF_EN
                check("rst_stall_cycles", stall_cycles, 32'h0);
`endif
                req_pc_m  = RESET_PC;
                prev_wait = 1'b0;
                exp_stall = 32'h0;
            end else begin
                if (!instr_valid) begin
                    check("bubble_instr", instr_IF, 32'h0);
                    check("bubble_pc", pc, 32'h0);
                end
                if (!pc_running || branch_valid) begin
                    check("req_blocked", {31'h0, imem_req_valid}, 32'h0);
                end
                if (prev_wait) begin
                    check("req_addr_hold", imem_req_addr, prev_addr);
                end
                if (imem_req_valid) begin
                    check("req_addr", imem_req_addr, req_pc_m);
                end
                check("inflight_bound", (mem_q.size() <= FIFO_DEPTH) ? 32'd1 : 32'd0, 32'd1);
                if (instr_valid && !keep_instr && !branch_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL instr_unexpected: got pc %h with no expected entry (cycle %0d)", pc, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", pc, e[63:32]);
                        check("instr_data", instr_IF, e[31:0]);
                        consumed++;
                    end
                end
`ifdef IF_PERF_EN
                check("stall_cycles", stall_cycles, exp_stall);
                if (pc_running && !instr_valid && !keep_instr && exp_stall != 32'hFFFF_FFFF) begin
                    exp_stall += 32'd1;
                end
`endif
                if (branch_valid) begin
                    req_pc_m = branch_target & 32'hFFFF_FFFC;
                end else if (imem_req_valid && imem_req_ready) begin
                    req_pc_m += 32'd4;
                end
                prev_wait = imem_req_valid && !imem_req_ready;
                prev_addr = imem_req_addr;
            end
        end
    end

endmodule
